// File: rtl/cdc_burst_source.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_burst_source : buffers a ready/valid word stream and emits gapped bursts
// Revision 1.0
// ----------------------------------------------------------------------------
module cdc_burst_source #(
   parameter int WIDTH         = 8,
   parameter int BURST_LEN     = 16,
   parameter int IPG           = 8,
   parameter int BUF_DEPTH     = 32,
   parameter int FLUSH_TIMEOUT = 64
) (
   input  logic             clk_a,
   input  logic             rst_n,
   input  logic             en,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   output logic             s_ready,
   output logic             valid_a,
   output logic [WIDTH-1:0] data_a,
   output logic             busy,
   output logic [15:0]      bursts_sent
);

   localparam int AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW    = $clog2(BUF_DEPTH + 1);
   localparam int RW    = $clog2(BURST_LEN + 1);
   localparam int GAP_N = (IPG < 1) ? 1 : IPG;
   localparam int GW    = $clog2(GAP_N + 1);
   localparam int TW    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

   localparam logic [CW-1:0] C_FULL  = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] C_BURST = CW'(BURST_LEN);
   localparam logic [GW-1:0] C_GAPM1 = GW'(GAP_N - 1);
   localparam logic [TW-1:0] C_TOUT  = TW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state;
   logic [WIDTH:0]  mem [BUF_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   last_cnt;
   logic [RW-1:0]   rem;
   logic [GW-1:0]   gap_cnt;
   logic [TW-1:0]   idle_tmr;
   logic            push;
   logic            pop;
   logic            start;
   logic [WIDTH:0]  head;

   assign s_ready = rst_n & (count != C_FULL);
   assign push    = s_valid & s_ready;
   assign pop     = (state == SEND);
   assign head    = mem[rd_ptr];

   always_comb begin
      start = 1'b0;
      if (state == IDLE && en) begin
         if (count >= C_BURST || last_cnt != '0)
            start = 1'b1;
         if (FLUSH_TIMEOUT != 0 && count != '0 && idle_tmr == C_TOUT)
            start = 1'b1;
      end
   end

   // Storage carries no reset; pointers and count define which entries are live.
   always_ff @(posedge clk_a) begin
      if (push)
         mem[wr_ptr] <= {s_last, s_data};
   end

   always_ff @(posedge clk_a) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         last_cnt    <= '0;
         rem         <= '0;
         gap_cnt     <= '0;
         idle_tmr    <= '0;
         valid_a     <= 1'b0;
         data_a      <= '0;
         busy        <= 1'b0;
         bursts_sent <= '0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(push);
         count    <= count + CW'(push) - CW'(pop);
         last_cnt <= last_cnt + CW'(push & s_last) - CW'(pop & head[WIDTH]);

         if (push || start || count == '0)
            idle_tmr <= '0;
         else if (state == IDLE && idle_tmr != '1)
            idle_tmr <= idle_tmr + TW'(1);

         case (state)
            IDLE: begin
               valid_a <= 1'b0;
               if (start) begin
                  rem   <= (count >= C_BURST) ? RW'(BURST_LEN) : RW'(count);
                  busy  <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               // rem never exceeds count at start, so the head is always valid here.
               valid_a <= 1'b1;
               data_a  <= head[WIDTH-1:0];
               rd_ptr  <= rd_ptr + AW'(1);
               rem     <= rem - RW'(1);
               if (head[WIDTH] || rem == RW'(1)) begin
                  bursts_sent <= bursts_sent + 16'd1;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end
            end
            GAP: begin
               valid_a <= 1'b0;
               if (gap_cnt == C_GAPM1) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdc_burst_source.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cdc_burst_source : directed self-checking bench for cdc_burst_source
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_cdc_burst_source;

   logic        clk_a = 1'b0;
   logic        rst_n;
   logic        en;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        valid_a;
   logic [7:0]  data_a;
   logic        busy;
   logic [15:0] bursts_sent;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;

   // Output monitor state
   logic [7:0] obs[$];
   int         blens[$];
   int         gaps[$];
   int         cur_len  = 0;
   int         low_run  = 0;
   int         had_burst = 0;

   cdc_burst_source #(
      .WIDTH(8), .BURST_LEN(16), .IPG(8), .BUF_DEPTH(32), .FLUSH_TIMEOUT(64)
   ) dut (
      .clk_a(clk_a), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .valid_a(valid_a), .data_a(data_a),
      .busy(busy), .bursts_sent(bursts_sent)
   );

   always #5 clk_a = ~clk_a;

   always @(negedge clk_a) begin
      if (valid_a === 1'b1) begin
         if (cur_len == 0 && had_burst != 0)
            gaps.push_back(low_run);
         obs.push_back(data_a);
         cur_len = cur_len + 1;
         low_run = 0;
      end else begin
         if (cur_len != 0) begin
            blens.push_back(cur_len);
            had_burst = 1;
         end
         cur_len = 0;
         low_run = low_run + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] d, input logic l);
      int t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && t < 3000) begin
         @(negedge clk_a);
         t++;
      end
      if (t >= 3000) chk("push_timeout", 32'd0, 32'd1);
      @(negedge clk_a);
      n_acc++;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_bursts(input string tag, input int target, input int limit);
      int t = 0;
      while (int'(bursts_sent) != target && t < limit) begin
         @(negedge clk_a);
         t++;
      end
      chk(tag, {16'd0, bursts_sent}, target);
      repeat (3) @(negedge clk_a);
   endtask

   task automatic check_words(input string tag, input int base, input int first, input int n);
      chk({tag, "_count"}, obs.size() - base, n);
      for (int i = 0; i < n; i++)
         if (base + i < obs.size())
            chk(tag, obs[base + i], (first + i) & 8'hFF);
   endtask

   int ob, bb, gb, mg, bs;

   initial begin
      rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_a);
      @(negedge clk_a);
      chk("rst_valid", valid_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bursts", bursts_sent, 0);
      chk("rst_ready", s_ready, 0);
      rst_n = 1'b1;
      @(negedge clk_a);
      chk("ready_after_rst", s_ready, 1);

      // 16 words, no last: one full burst
      en = 1'b1;
      ob = obs.size(); bb = blens.size();
      for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0);
      wait_bursts("t2_bursts", 1, 200);
      check_words("t2_data", ob, 8'h00, 16);
      chk("t2_len", (blens.size() > bb) ? blens[bb] : -1, 16);
      repeat (12) @(negedge clk_a);
      chk("t2_gap", (low_run >= 8), 1);

      // 40 words: 16, 16, then flush of 8
      ob = obs.size(); bb = blens.size(); gb = gaps.size();
      for (int i = 0; i < 40; i++) push_word(8'(8'h20 + i), 1'b0);
      wait_bursts("t3_bursts", 4, 2000);
      check_words("t3_data", ob, 8'h20, 40);
      chk("t3_nbursts", blens.size() - bb, 3);
      if (blens.size() >= bb + 3) begin
         chk("t3_len0", blens[bb], 16);
         chk("t3_len1", blens[bb + 1], 16);
         chk("t3_len2", blens[bb + 2], 8);
      end
      mg = 1000;
      for (int i = gb; i < gaps.size(); i++) if (gaps[i] < mg) mg = gaps[i];
      chk("t3_min_gap", (mg >= 8), 1);

      // 5-word packet bursts without timeout; then last mid-stream stays split
      ob = obs.size(); bb = blens.size();
      for (int i = 0; i < 5; i++) push_word(8'(8'h60 + i), (i == 4));
      wait_bursts("t4_no_timeout", 5, 30);
      chk("t4_len", (blens.size() > bb) ? blens[bb] : -1, 5);
      check_words("t4_data", ob, 8'h60, 5);
      ob = obs.size(); bb = blens.size();
      push_word(8'h70, 1'b0);
      push_word(8'h71, 1'b1);
      push_word(8'h72, 1'b0);
      wait_bursts("t4b_bursts", 7, 300);
      chk("t4b_nbursts", blens.size() - bb, 2);
      if (blens.size() >= bb + 2) begin
         chk("t4b_len0", blens[bb], 2);
         chk("t4b_len1", blens[bb + 1], 1);
      end
      check_words("t4b_data", ob, 8'h70, 3);

      // en=0 fills buffer; word 33 held until space frees
      en = 1'b0;
      ob = obs.size(); bb = blens.size();
      n_acc = 0;
      fork
         for (int i = 0; i < 33; i++) push_word(8'(8'h80 + i), 1'b0);
         begin
            repeat (120) @(negedge clk_a);
            chk("t5_accepted", n_acc, 32);
            chk("t5_ready_full", s_ready, 0);
            chk("t5_no_output", obs.size() - ob, 0);
            en = 1'b1;
         end
      join
      wait_bursts("t5_bursts", 10, 3000);
      chk("t5_nbursts", blens.size() - bb, 3);
      if (blens.size() >= bb + 3) begin
         chk("t5_len0", blens[bb], 16);
         chk("t5_len1", blens[bb + 1], 16);
         chk("t5_len2", blens[bb + 2], 1);
      end
      check_words("t5_data", ob, 8'h80, 33);

      // Reset after the 7th word of a burst
      for (int i = 0; i < 16; i++) push_word(8'(8'hC0 + i), 1'b0);
      begin
         int t = 0;
         while (cur_len != 7 && t < 200) begin
            @(negedge clk_a);
            #1;
            t++;
         end
         chk("t6_seven_seen", cur_len, 7);
      end
      rst_n = 1'b0;
      @(negedge clk_a);
      chk("t6_valid_off", valid_a, 0);
      chk("t6_bursts_clr", bursts_sent, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready_rst", s_ready, 0);
      rst_n = 1'b1;
      bs = obs.size();
      repeat (150) @(negedge clk_a);
      chk("t6_no_more_out", obs.size() - bs, 0);
      chk("t6_ready_empty", s_ready, 1);
      chk("t6_bursts_end", bursts_sent, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
